// File: rtl/gpio_msg_queue.sv
// gpio_msg_queue: TX message FIFO feeding a handshake link, plus a single-entry
// RX capture register fed by an asynchronous "received" strobe from the link.
module gpio_msg_queue #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     tx_valid,
   input  logic [WIDTH-1:0]         tx_data,
   output logic                     tx_ready,
   output logic                     link_data_ready,
   output logic [WIDTH-1:0]         link_message_out,
   input  logic                     link_done,
   input  logic                     link_received,
   input  logic [WIDTH-1:0]         link_message_in,
   output logic                     rx_valid,
   output logic [WIDTH-1:0]         rx_data,
   input  logic                     rx_ready,
   output logic [$clog2(DEPTH):0]   tx_count,
   output logic                     rx_overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEND    = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t            state;
   logic [WIDTH-1:0]  mem [DEPTH];
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr_next;
   logic [CW-1:0]     count_next;
   logic [WIDTH-1:0]  head_next;
   logic              push;
   logic              pop;

   logic              rx_sync1;
   logic              rx_sync2;
   logic              rx_prev;
   logic              capture;

   // Handshake decode, next pointer/count, and the entry that will sit at the head
   always_comb begin
      push        = tx_valid && tx_ready;
      pop         = (state == SEND) && link_done;
      rd_ptr_next = pop ? rd_ptr + PW'(1) : rd_ptr;
      count_next  = tx_count;
      case ({push, pop})
         2'b10:   count_next = tx_count + CW'(1);
         2'b01:   count_next = tx_count - CW'(1);
         default: count_next = tx_count;
      endcase
      // A word being written into the slot that becomes the head is not in mem yet,
      // so forward it straight from the input.
      if (push && (wr_ptr == rd_ptr_next)) begin
         head_next = tx_data;
      end else begin
         head_next = mem[rd_ptr_next];
      end
      capture = rx_sync2 && !rx_prev;
   end

   // FIFO storage; contents are deliberately left untouched by reset
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= tx_data;
      end
   end

   // Pointers, occupancy, push-side ready and the registered head word
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr           <= '0;
         wr_ptr           <= '0;
         tx_count         <= '0;
         tx_ready         <= 1'b0;
         link_message_out <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         rd_ptr           <= rd_ptr_next;
         tx_count         <= count_next;
         tx_ready         <= (count_next != FULL);
         link_message_out <= head_next;
      end
   end

   // TX sequencer: data_ready rises with entry to SEND, falls on done, then one
   // RELEASE cycle plus the IDLE cycle give the link two low cycles to rewind
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         link_data_ready <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (tx_count != '0) begin
                  state           <= SEND;
                  link_data_ready <= 1'b1;
               end
            end
            SEND: begin
               if (link_done) begin
                  state           <= RELEASE;
                  link_data_ready <= 1'b0;
               end
            end
            RELEASE: begin
               state           <= IDLE;
               link_data_ready <= 1'b0;
            end
            default: begin
               state           <= IDLE;
               link_data_ready <= 1'b0;
            end
         endcase
      end
   end

   // Two-flop synchroniser for the asynchronous received flag plus edge-detect history
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rx_sync1 <= 1'b0;
         rx_sync2 <= 1'b0;
         rx_prev  <= 1'b0;
      end else begin
         rx_sync1 <= link_received;
         rx_sync2 <= rx_sync1;
         rx_prev  <= rx_sync2;
      end
   end

   // RX holding register: capture beats a simultaneous accept; a capture into an
   // unread, unaccepted slot is dropped and latched as a sticky overflow
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rx_valid    <= 1'b0;
         rx_data     <= '0;
         rx_overflow <= 1'b0;
      end else begin
         if (capture) begin
            if (!rx_valid || rx_ready) begin
               rx_data  <= link_message_in;
               rx_valid <= 1'b1;
            end else begin
               rx_overflow <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule
